pipelined_ks_adder: RTL

PIPELINED_KS_ADDER -- requirements
Module: pipelined_ks_adder

---
 rtl/pipelined_ks_adder_if.sv | 27 ++
 rtl/pipelined_ks_adder.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipelined_ks_adder_if.sv
// Operand/result stream bundle for the pipelined Kogge-Stone adder.
// master drives operands and result back-pressure; slave is the adder.
interface pipelined_ks_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x1, x2, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, x1, x2, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone adder/subtractor: one prefix level per stage,
// LEVELS+2 registers deep, single global stall enable.
module pipelined_ks_adder #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_ks_adder_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);

  generate
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_ks_adder: WIDTH must be a power of two in 4..64");
    end
  endgenerate

  logic advance;

  // Index 0 is the generate/propagate stage, index k holds prefix level k.
  logic [LEVELS:0]            vld;
  logic [LEVELS:0][WIDTH-1:0] gg;
  logic [LEVELS:0][WIDTH-1:0] pp;
  logic [LEVELS:0][WIDTH-1:0] praw;
  logic [LEVELS:0]            c0;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  logic             out_valid_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;

  assign advance      = ~out_valid_r | bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

  // Carry-in is folded into g[0] so the prefix tree yields true carries.
  always_comb begin
    b_eff   = bus.sub ? ~bus.x2 : bus.x2;
    c0_in   = bus.sub | bus.cin;
    p_in    = bus.x1 ^ b_eff;
    g_in    = bus.x1 & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
  end

  always_comb begin
    sum_c    = '0;
    sum_c[0] = praw[LEVELS][0] ^ c0[LEVELS];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      sum_c[i] = praw[LEVELS][i] ^ gg[LEVELS][i-1];
    end
    cout_c = gg[LEVELS][WIDTH-1];
    ovf_c  = gg[LEVELS][WIDTH-2] ^ cout_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld         <= '0;
      out_valid_r <= 1'b0;
      s_r         <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (advance) begin
      vld     <= {vld[LEVELS-1:0], bus.in_valid};
      gg[0]   <= g_in;
      pp[0]   <= p_in;
      praw[0] <= p_in;
      c0[0]   <= c0_in;

      for (int unsigned k = 1; k <= LEVELS; k++) begin
        praw[k] <= praw[k-1];
        c0[k]   <= c0[k-1];
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (i >= (32'd1 << (k - 1))) begin
            gg[k][i] <= gg[k-1][i] | (pp[k-1][i] & gg[k-1][i - (32'd1 << (k - 1))]);
            pp[k][i] <= pp[k-1][i] & pp[k-1][i - (32'd1 << (k - 1))];
          end else begin
            gg[k][i] <= gg[k-1][i];
            pp[k][i] <= pp[k-1][i];
          end
        end
      end

      out_valid_r <= vld[LEVELS];
      s_r         <= vld[LEVELS] ? sum_c : '0;
      cout_r      <= vld[LEVELS] & cout_c;
      ovf_r       <= vld[LEVELS] & ovf_c;
    end
  end
endmodule
